// File: rtl/vita49_pkg.sv
// rtl/vita49_pkg.sv - shared VITA-49 header fields, ctrl/status bits, parser states
package vita49_pkg;

  // Header word field positions
  localparam int HDR_TYPE_HI = 31;
  localparam int HDR_TYPE_LO = 28;
  localparam int HDR_C       = 27;
  localparam int HDR_T       = 26;
  localparam int HDR_TSI_HI  = 23;
  localparam int HDR_TSI_LO  = 22;
  localparam int HDR_TSF_HI  = 21;
  localparam int HDR_TSF_LO  = 20;
  localparam int HDR_SEQ_HI  = 19;
  localparam int HDR_SEQ_LO  = 16;
  localparam int HDR_SIZE_HI = 15;
  localparam int HDR_SIZE_LO = 0;

  localparam logic [3:0] PKT_TYPE_IF_DATA = 4'b0001;

  // ctrl / status bit indices
  localparam int CTRL_EN     = 0;
  localparam int CTRL_SRST   = 1;
  localparam int CTRL_PASS   = 2;
  localparam int CTRL_SIDCHK = 3;
  localparam int CTRL_TSCAP  = 4;

  // Parser states, numbered in packet order so "next optional field" is a compare
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_SID     = 4'd1;
  localparam logic [3:0] ST_CID0    = 4'd2;
  localparam logic [3:0] ST_CID1    = 4'd3;
  localparam logic [3:0] ST_TSI     = 4'd4;
  localparam logic [3:0] ST_TSF0    = 4'd5;
  localparam logic [3:0] ST_TSF1    = 4'd6;
  localparam logic [3:0] ST_PAYLOAD = 4'd7;
  localparam logic [3:0] ST_TRL     = 4'd8;
  localparam logic [3:0] ST_DROP    = 4'd9;
  localparam logic [3:0] ST_PASS    = 4'd10;

  // Number of non-payload words (header, SID, CID, TSI, TSF, trailer)
  function automatic logic [15:0] hdr_overhead(input logic [31:0] hdr);
    logic [15:0] n;
    n = 16'd2;
    if (hdr[HDR_C]) n = n + 16'd2;
    if (hdr[HDR_TSI_HI:HDR_TSI_LO] != 2'b00) n = n + 16'd1;
    if (hdr[HDR_TSF_HI:HDR_TSF_LO] != 2'b00) n = n + 16'd2;
    if (hdr[HDR_T]) n = n + 16'd1;
    return n;
  endfunction

  // First present field strictly after cur; later checks override, so the nearest wins
  function automatic logic [3:0] next_parse(input logic [3:0] cur, input logic c, input logic t,
                                            input logic tsi, input logic tsf, input logic pay);
    logic [3:0] n;
    n = ST_IDLE;
    if (t   && cur < ST_TRL)     n = ST_TRL;
    if (pay && cur < ST_PAYLOAD) n = ST_PAYLOAD;
    if (tsf && cur < ST_TSF1)    n = ST_TSF1;
    if (tsf && cur < ST_TSF0)    n = ST_TSF0;
    if (tsi && cur < ST_TSI)     n = ST_TSI;
    if (c   && cur < ST_CID1)    n = ST_CID1;
    if (c   && cur < ST_CID0)    n = ST_CID0;
    return n;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - 1-deep registered AXI-Stream stage
module axis_reg_slice #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_s_tdata,
  input  logic         i_s_tvalid,
  output logic         o_s_tready,
  input  logic         i_s_tlast,
  output logic [W-1:0] o_m_tdata,
  output logic         o_m_tvalid,
  input  logic         i_m_tready,
  output logic         o_m_tlast
);

  logic [W-1:0] r_data;
  logic         r_valid;
  logic         r_last;
  logic         w_s_ready;

  assign w_s_ready  = !r_valid || i_m_tready;
  assign o_s_tready = w_s_ready;
  assign o_m_tdata  = r_data;
  assign o_m_tvalid = r_valid;
  assign o_m_tlast  = r_last;

  // Load whenever the held word is empty or leaving; otherwise hold stable
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_s_ready) begin
      r_data  <= i_s_tdata;
      r_valid <= i_s_tvalid;
      r_last  <= i_s_tlast;
    end
  end

endmodule

// File: rtl/vita49_unpack.sv
// rtl/vita49_unpack.sv - VITA-49 IF data packet parser and payload extractor
module vita49_unpack
  import vita49_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              AXIS_ACLK,
  input  logic              AXIS_ARESET,
  input  logic [DATA_W-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  output logic              S_AXIS_TREADY,
  input  logic              S_AXIS_TLAST,
  output logic [DATA_W-1:0] M_AXIS_TDATA,
  output logic              M_AXIS_TVALID,
  input  logic              M_AXIS_TREADY,
  output logic              M_AXIS_TLAST,
  input  logic [31:0]       ctrl,
  output logic [31:0]       status,
  input  logic [31:0]       streamID,
  output logic [31:0]       trailer,
  output logic [31:0]       timestamp_sec,
  output logic [63:0]       timestamp_fsec,
  output logic              ts_valid
);

  logic             w_rst, w_s_hs, w_tready, w_final;
  logic             w_sl_valid, w_sl_last, w_sl_ready;
  logic [3:0]       w_next, w_h_type, w_h_seq;
  logic [15:0]      w_h_size, w_h_ovh;
  logic             w_h_bad, w_unused;
  logic [31:0]      w_tsi_cur;
  logic [63:0]      w_tsf_cur;
  logic [3:0]       r_state, r_prev_seq;
  logic             r_c, r_t, r_tsi_nz, r_tsf_nz, r_seq_seen;
  logic [15:0]      r_size, r_widx, r_pay;
  logic             r_sid_err, r_len_err, r_seq_err, r_type_err;
  logic [CNT_W-1:0] r_pkts;
  logic [31:0]      r_tsi_tmp, r_trailer, r_ts_sec;
  logic [63:0]      r_tsf_tmp, r_ts_fsec;
  logic             r_ts_valid;

  assign w_rst    = AXIS_ARESET || ctrl[CTRL_SRST];
  assign w_s_hs   = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_unused = ^ctrl[31:5];

  assign w_h_type = S_AXIS_TDATA[HDR_TYPE_HI:HDR_TYPE_LO];
  assign w_h_seq  = S_AXIS_TDATA[HDR_SEQ_HI:HDR_SEQ_LO];
  assign w_h_size = S_AXIS_TDATA[HDR_SIZE_HI:HDR_SIZE_LO];
  assign w_h_ovh  = hdr_overhead(S_AXIS_TDATA);
  assign w_h_bad  = (w_h_type != PKT_TYPE_IF_DATA) || (w_h_size < w_h_ovh);

  assign w_final   = (r_widx == r_size - 16'd1);
  assign w_next    = next_parse(r_state, r_c, r_t, r_tsi_nz, r_tsf_nz, r_pay != 16'd0);
  // Timestamp words may themselves be the final word of a zero-payload packet
  assign w_tsi_cur = (r_state == ST_TSI)  ? S_AXIS_TDATA : r_tsi_tmp;
  assign w_tsf_cur = (r_state == ST_TSF1) ? {r_tsf_tmp[63:32], S_AXIS_TDATA} : r_tsf_tmp;

  assign w_sl_valid = S_AXIS_TVALID && !w_rst && (r_state == ST_PAYLOAD || r_state == ST_PASS);
  assign w_sl_last  = (r_state == ST_PASS) ? S_AXIS_TLAST : (S_AXIS_TLAST || r_pay == 16'd1);

  axis_reg_slice #(.W(DATA_W)) u_out (
    .i_clk      (AXIS_ACLK),
    .i_rst      (w_rst),
    .i_s_tdata  (S_AXIS_TDATA),
    .i_s_tvalid (w_sl_valid),
    .o_s_tready (w_sl_ready),
    .i_s_tlast  (w_sl_last),
    .o_m_tdata  (M_AXIS_TDATA),
    .o_m_tvalid (M_AXIS_TVALID),
    .i_m_tready (M_AXIS_TREADY),
    .o_m_tlast  (M_AXIS_TLAST)
  );

  // Input ready: gated by enable in IDLE, backpressured in streaming states
  always_comb begin
    w_tready = 1'b1;
    case (r_state)
      ST_IDLE:             w_tready = ctrl[CTRL_EN] && !ctrl[CTRL_PASS];
      ST_PAYLOAD, ST_PASS: w_tready = w_sl_ready;
      default:             ;
    endcase
    if (w_rst) w_tready = 1'b0;
  end
  assign S_AXIS_TREADY = w_tready;

  // Packet parser: field walk, length/SID/type/seq checks, counters and captures
  always_ff @(posedge AXIS_ACLK) begin
    if (w_rst) begin
      r_state <= ST_IDLE;   r_prev_seq <= '0;  r_seq_seen <= 1'b0;
      r_c <= 1'b0;          r_t <= 1'b0;       r_tsi_nz <= 1'b0;   r_tsf_nz <= 1'b0;
      r_size <= '0;         r_widx <= '0;      r_pay <= '0;
      r_sid_err <= 1'b0;    r_len_err <= 1'b0; r_seq_err <= 1'b0;  r_type_err <= 1'b0;
      r_pkts <= '0;         r_tsi_tmp <= '0;   r_tsf_tmp <= '0;
      r_trailer <= '0;      r_ts_sec <= '0;    r_ts_fsec <= '0;    r_ts_valid <= 1'b0;
    end else begin
      r_ts_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_s_hs) begin
            r_c      <= S_AXIS_TDATA[HDR_C];
            r_t      <= S_AXIS_TDATA[HDR_T];
            r_tsi_nz <= S_AXIS_TDATA[HDR_TSI_HI:HDR_TSI_LO] != 2'b00;
            r_tsf_nz <= S_AXIS_TDATA[HDR_TSF_HI:HDR_TSF_LO] != 2'b00;
            r_size   <= w_h_size;
            r_widx   <= 16'd1;
            r_pay    <= w_h_size - w_h_ovh;
            r_tsi_tmp <= '0;
            r_tsf_tmp <= '0;
            if (w_h_bad) begin
              r_type_err <= 1'b1;
              r_state    <= S_AXIS_TLAST ? ST_IDLE : ST_DROP;
            end else begin
              if (r_seq_seen && w_h_seq != r_prev_seq + 4'd1) r_seq_err <= 1'b1;
              r_prev_seq <= w_h_seq;
              r_seq_seen <= 1'b1;
              if (S_AXIS_TLAST) r_len_err <= 1'b1;
              else              r_state   <= ST_SID;
            end
          end else if (ctrl[CTRL_PASS] && S_AXIS_TVALID) begin
            r_state <= ST_PASS;
          end
        end
        ST_DROP, ST_PASS: begin
          if (w_s_hs && S_AXIS_TLAST) r_state <= ST_IDLE;
        end
        default: begin
          if (w_s_hs) begin
            r_widx <= r_widx + 16'd1;
            case (r_state)
              ST_TSI:     r_tsi_tmp         <= S_AXIS_TDATA;
              ST_TSF0:    r_tsf_tmp[63:32]  <= S_AXIS_TDATA;
              ST_TSF1:    r_tsf_tmp[31:0]   <= S_AXIS_TDATA;
              ST_PAYLOAD: r_pay             <= r_pay - 16'd1;
              default:    ;
            endcase
            if (r_state == ST_SID && ctrl[CTRL_SIDCHK] && S_AXIS_TDATA != streamID) begin
              r_sid_err <= 1'b1;
              r_state   <= S_AXIS_TLAST ? ST_IDLE : ST_DROP;
            end else if (w_final) begin
              if (S_AXIS_TLAST) begin
                r_pkts  <= r_pkts + 1'b1;
                r_state <= ST_IDLE;
                if (ctrl[CTRL_TSCAP]) begin
                  r_ts_sec   <= w_tsi_cur;
                  r_ts_fsec  <= w_tsf_cur;
                  r_ts_valid <= 1'b1;
                  if (r_t) r_trailer <= S_AXIS_TDATA;
                end
              end else begin
                r_len_err <= 1'b1;
                r_state   <= ST_DROP;
              end
            end else if (S_AXIS_TLAST) begin
              r_len_err <= 1'b1;
              r_state   <= ST_IDLE;
            end else if (!(r_state == ST_PAYLOAD && r_pay != 16'd1)) begin
              r_state <= w_next;
            end
          end
        end
      endcase
    end
  end

  assign status = {16'(r_pkts), 11'd0, r_type_err, r_seq_err, r_len_err, r_sid_err,
                   (r_state != ST_IDLE) || M_AXIS_TVALID};
  assign trailer        = r_trailer;
  assign timestamp_sec  = r_ts_sec;
  assign timestamp_fsec = r_ts_fsec;
  assign ts_valid       = r_ts_valid;

endmodule
